// File: rtl/idt_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// idt_cfg_ctrl
//
// Serial programming controller for an IDT clock synthesizer. A 24-bit
// configuration word {C[1:0],TTL,F[1:0],S[2:0],V[8:0],R[6:0]} is shifted out
// MSB first on idt_data/idt_sclk. A load strobe follows, then a fixed wait
// while the PLL locks. Completion is reported with a one-cycle cfg_done pulse
// and a sticky cfg_valid flag.
//
// Optional build macro: IDT_CFG_AUTO_EN
//   When defined, the first cycle after reset is released behaves as an
//   accepted request carrying DEFAULT_CFG, whatever cfg_req is doing.
//   When undefined, the block only leaves IDLE on cfg_req.
//
// Clocking/reset: single clock osc_clk (rising edge), synchronous
// active-high reset osc_reset. All outputs are driven straight from flops,
// so idt_sclk/idt_data/idt_strobe are glitch-free at the synthesizer pins.
// -----------------------------------------------------------------------------
module idt_cfg_ctrl #(
  parameter int unsigned CLK_DIV     = 2,          // osc_clk cycles per sclk half-period (1..255)
  parameter int unsigned LOCK_WAIT   = 1024,       // osc_clk cycles of PLL lock wait (1..65535)
  parameter logic [23:0] DEFAULT_CFG = 24'h2B0404  // power-up configuration word
) (
  input  logic        osc_clk,
  input  logic        osc_reset,
  input  logic        cfg_req,
  input  logic [23:0] cfg_word,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_valid,
  output logic        idt_sclk,
  output logic        idt_data,
  output logic        idt_strobe
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    STROBE = 2'd2,
    WAIT   = 2'd3
  } state_e;

  // Terminal counts. The divider only counts one half-period; a separate
  // phase bit selects the low/high half, so 2*CLK_DIV never has to fit in
  // the 8-bit divider.
  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [4:0]  BIT_LAST  = 5'd23;
  localparam logic [15:0] WAIT_LAST = 16'(LOCK_WAIT - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e      state_q,    state_d;
  logic [23:0] shift_q,    shift_d;
  logic [4:0]  bit_cnt_q,  bit_cnt_d;
  logic [7:0]  div_cnt_q,  div_cnt_d;
  logic        phase_q,    phase_d;     // 0: sclk-low half, 1: sclk-high half
  logic [15:0] wait_cnt_q, wait_cnt_d;

  // Registered outputs and their next values
  logic busy_q,   busy_d;
  logic done_q,   done_d;
  logic valid_q,  valid_d;
  logic sclk_q,   sclk_d;
  logic data_q,   data_d;
  logic strobe_q, strobe_d;

  // Request source: either the external port or the post-reset auto start
  logic        start;
  logic [23:0] start_word;

  logic half_end;    // last cycle of the current sclk half-period
  logic period_end;  // last cycle of a full bit (or strobe) period

`ifdef IDT_CFG_AUTO_EN
  logic auto_q;

  // Remember that reset was active last cycle; it is high for exactly the
  // first cycle after reset is released, which becomes the auto request.
  always_ff @(posedge osc_clk) begin
    auto_q <= osc_reset;
  end

  assign start      = cfg_req | auto_q;
  assign start_word = auto_q ? DEFAULT_CFG : cfg_word;
`else
  assign start      = cfg_req;
  assign start_word = cfg_word;
`endif

  assign half_end   = (div_cnt_q == DIV_LAST);
  assign period_end = half_end & phase_q;

  // Next-state, counter and output decode for the four-state sequencer
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    phase_d    = phase_q;
    wait_cnt_d = wait_cnt_q;
    valid_d    = valid_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Requests are only looked at here, so anything arriving while busy
        // is dropped rather than queued.
        if (start) begin
          state_d    = SHIFT;
          shift_d    = start_word;
          bit_cnt_d  = '0;
          div_cnt_d  = '0;
          phase_d    = 1'b0;
          valid_d    = 1'b0;
        end
      end

      SHIFT: begin
        if (half_end) begin
          div_cnt_d = '0;
          phase_d   = ~phase_q;
          if (phase_q) begin
            // End of a bit: advance to the next one, or hand off to the
            // strobe after bit 0 has been clocked out.
            shift_d = {shift_q[22:0], 1'b0};
            if (bit_cnt_q == BIT_LAST) begin
              state_d   = STROBE;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      STROBE: begin
        // The strobe reuses the bit-period timing: 2*CLK_DIV cycles.
        if (half_end) begin
          div_cnt_d = '0;
          phase_d   = ~phase_q;
          if (period_end) begin
            state_d    = WAIT;
            wait_cnt_d = '0;
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
          done_d     = 1'b1;
          valid_d    = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are computed from the next state so that, once registered,
    // they line up exactly with the state they describe.
    busy_d   = (state_d != IDLE);
    sclk_d   = (state_d == SHIFT) & phase_d;
    data_d   = (state_d == SHIFT) & shift_d[23];
    strobe_d = (state_d == STROBE);
  end

  // State, counters and registered outputs, with synchronous reset
  always_ff @(posedge osc_clk) begin
    // NOTE: sequential state is assigned with <= only, so every flop samples
    // the pre-edge values regardless of statement order.
    if (osc_reset) begin
      state_q    <= IDLE;
      shift_q    <= DEFAULT_CFG;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      phase_q    <= 1'b0;
      wait_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      sclk_q     <= 1'b0;
      data_q     <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      phase_q    <= phase_d;
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      sclk_q     <= sclk_d;
      data_q     <= data_d;
      strobe_q   <= strobe_d;
    end
  end

  assign cfg_busy   = busy_q;
  assign cfg_done   = done_q;
  assign cfg_valid  = valid_q;
  assign idt_sclk   = sclk_q;
  assign idt_data   = data_q;
  assign idt_strobe = strobe_q;

endmodule
